battleship_shot_engine: RTL and testbench

- Parametrised successor to the combinational shot checker and HEX driver.
- Accepts a fire request from user switches/key, validates it, and queries an external ship map one cell at a time through a req/ack handshake. A big bomb covers a 3x3 area.
- Classifies the shot as hit, near-miss or miss, tracks big bombs and total hits, and drives an N-digit seven-segment hit counter with leading-zero blanking.

---
 rtl/battleship_pkg.sv | 43 ++++
 rtl/seg7_digit_blank.sv | 15 +
 rtl/battleship_shot_engine.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_battleship_shot_engine.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship shot engine.
//   state_t        : shot sequencer states (IDLE, QUERY, DONE)
//   shot_result_t  : classification of the last completed shot
//   SEG_BLANK      : all segments off (active-low)
//   SEG_DASH       : middle segment only, used when the count cannot be shown
//   seg_digit()    : 0-9 decimal to active-low gfedcba segment table
package battleship_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_HIT  = 2'd1,
    RES_NEAR = 2'd2,
    RES_MISS = 2'd3
  } shot_result_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b100_0000;
      4'd1:    s = 7'b111_1001;
      4'd2:    s = 7'b010_0100;
      4'd3:    s = 7'b011_0000;
      4'd4:    s = 7'b001_1001;
      4'd5:    s = 7'b001_0010;
      4'd6:    s = 7'b000_0010;
      4'd7:    s = 7'b111_1000;
      4'd8:    s = 7'b000_0000;
      4'd9:    s = 7'b001_0000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_digit_blank.sv
// One seven-segment digit with blanking.
//   bcd_i   : BCD digit 0-9
//   blank_i : force all segments off
//   seg_o   : active-low segments, gfedcba
module seg7_digit_blank
  import battleship_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg_digit(bcd_i);

endmodule

// File: rtl/battleship_shot_engine.sv
// Battleship shot engine: validates a fire request, walks the target cell
// (or the 3x3 area of a big bomb) through an external ship map, classifies
// the shot and keeps a saturating hit counter shown on seven-segment digits.
//   clock, reset_L          : clock, asynchronous active-low reset
//   fire, x, y, big         : fire level (acted on at its rising edge), target, big bomb
//   map_req/map_x/map_y     : map query out
//   map_ack/map_hit/map_near/map_ship : map response in
//   result_valid            : one-cycle pulse when a shot completes
//   hit/near_miss/miss      : one-hot result of the last completed shot
//   wrong                   : last fire attempt was illegal
//   big_left, hit_count, biggest_hit, game_over : game status
//   hex                     : active-low digits, hex[0] = units
//   state_dbg               : current sequencer state
//
// Map handshake: map_req is the valid; map_x/map_y hold steady while it is
// high. A cell transfers on any clock edge where map_req and map_ack are
// both 1 (ack may arrive in the same cycle as req). map_hit/map_near/map_ship
// are only looked at in that transfer cycle.
module battleship_shot_engine
  import battleship_pkg::*;
#(
  parameter int GRID        = 10,
  parameter int COORD_W     = 4,
  parameter int NUM_BIG     = 3,
  parameter int BIG_W       = 2,
  parameter int TOTAL_CELLS = 17,
  parameter int CNT_W       = 5,
  parameter int SHIP_W      = 3,
  parameter int NUM_DIGITS  = 2
) (
  input  logic                         clock,
  input  logic                         reset_L,
  input  logic                         fire,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic                         big,
  output logic                         map_req,
  output logic [COORD_W-1:0]           map_x,
  output logic [COORD_W-1:0]           map_y,
  input  logic                         map_ack,
  input  logic                         map_hit,
  input  logic                         map_near,
  input  logic [SHIP_W-1:0]            map_ship,
  output logic                         result_valid,
  output logic                         hit,
  output logic                         near_miss,
  output logic                         miss,
  output logic                         wrong,
  output logic [BIG_W-1:0]             big_left,
  output logic [CNT_W-1:0]             hit_count,
  output logic [SHIP_W-1:0]            biggest_hit,
  output logic                         game_over,
  output logic [NUM_DIGITS-1:0][6:0]   hex,
  output logic [1:0]                   state_dbg
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0]     GRID_W1  = CW1'(GRID);
  localparam logic [CNT_W:0]     TOTAL_W1 = (CNT_W+1)'(TOTAL_CELLS);
  localparam logic [CNT_W-1:0]   TOTAL_C  = CNT_W'(TOTAL_CELLS);
  localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);

  // Cell index 0..8 walks the 3x3 area in raster order; 4 is the centre.
  function automatic logic [1:0] off_x(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: off_x = 2'd0;
      4'd1, 4'd4, 4'd7: off_x = 2'd1;
      default:          off_x = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] off_y(input logic [3:0] idx);
    if (idx < 4'd3)      off_y = 2'd0;
    else if (idx < 4'd6) off_y = 2'd1;
    else                 off_y = 2'd2;
  endfunction

  // Widened by one bit so that a centre at the edge wraps below 1 or past
  // GRID instead of aliasing onto a legal coordinate.
  function automatic logic cell_ok(input logic [3:0] idx,
                                   input logic [COORD_W-1:0] cx,
                                   input logic [COORD_W-1:0] cy,
                                   input logic is_big);
    logic [CW1-1:0] px;
    logic [CW1-1:0] py;
    px = {1'b0, cx} + CW1'(off_x(idx)) - CW1'(1);
    py = {1'b0, cy} + CW1'(off_y(idx)) - CW1'(1);
    if (!is_big) cell_ok = (idx == 4'd4);
    else         cell_ok = (px != '0) && (px <= GRID_W1) && (py != '0) && (py <= GRID_W1);
  endfunction

  // {found, idx}: first on-grid cell at or after 'from'. Off-grid cells are
  // skipped here so they never cost a cycle.
  function automatic logic [4:0] next_cell(input logic [3:0] from,
                                           input logic [COORD_W-1:0] cx,
                                           input logic [COORD_W-1:0] cy,
                                           input logic is_big);
    logic [4:0] r;
    r = '0;
    for (int i = 8; i >= 0; i--) begin
      if (4'(i) >= from && cell_ok(4'(i), cx, cy, is_big)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  state_t                          state_q, state_d;
  logic                            fire_prev_q, fire_edge_q;
  logic [COORD_W-1:0]              cx_q, cx_d, cy_q, cy_d;
  logic                            big_sel_q, big_sel_d;
  logic [3:0]                      cell_q, cell_d;
  logic                            any_hit_q, any_hit_d, any_near_q, any_near_d;
  logic [3:0]                      tally_q, tally_d;
  logic [SHIP_W-1:0]               big_acc_q, big_acc_d;
  shot_result_t                    result_q, result_d;
  logic                            wrong_q, wrong_d;
  logic [BIG_W-1:0]                big_left_q, big_left_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [SHIP_W-1:0]               biggest_q, biggest_d;
  logic [NUM_DIGITS-1:0][3:0]      bcd_q, bcd_d;
  logic                            ovf_q, ovf_d;

  // Accumulators with the current cycle's response folded in.
  logic                            ack_now;
  logic                            hit_acc, near_acc;
  logic [3:0]                      tally_acc;
  logic [SHIP_W-1:0]               big_acc;
  logic                            illegal;
  logic [4:0]                      first_cell, later_cell;

  assign ack_now   = (state_q == ST_QUERY) && map_ack;
  assign hit_acc   = any_hit_q  | (ack_now & map_hit);
  assign near_acc  = any_near_q | (ack_now & map_near);
  assign tally_acc = tally_q + 4'(ack_now & map_hit);
  assign big_acc   = (ack_now && map_hit && (map_ship > big_acc_q)) ? map_ship : big_acc_q;

  assign illegal = (x == '0) || ({1'b0, x} > GRID_W1) ||
                   (y == '0) || ({1'b0, y} > GRID_W1) ||
                   (big && (big_left_q == '0));

  assign first_cell = next_cell(4'd0, x, y, big);
  assign later_cell = next_cell(cell_q + 4'd1, cx_q, cy_q, big_sel_q);

  // Saturated new count and the BCD digits advanced by the same amount.
  // The step is at most 9, so it enters the ripple chain as one digit.
  logic [CNT_W:0]                  sum_w;
  logic [CNT_W-1:0]                count_sat;
  logic [3:0]                      delta;
  logic [4:0]                      dsum;
  logic [NUM_DIGITS-1:0][3:0]      bcd_add;
  logic                            bcd_carry;

  always_comb begin
    sum_w     = {1'b0, count_q} + (CNT_W+1)'(tally_acc);
    count_sat = (sum_w >= TOTAL_W1) ? TOTAL_C : sum_w[CNT_W-1:0];
    delta     = 4'(count_sat - count_q);
    bcd_carry = 1'b0;
    dsum      = '0;
    bcd_add   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dsum = {1'b0, bcd_q[i]} + ((i == 0) ? {1'b0, delta} : 5'd0) + {4'd0, bcd_carry};
      if (dsum > 5'd9) begin
        bcd_add[i] = 4'(dsum - 5'd10);
        bcd_carry  = 1'b1;
      end else begin
        bcd_add[i] = dsum[3:0];
        bcd_carry  = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    big_sel_d  = big_sel_q;
    cell_d     = cell_q;
    any_hit_d  = any_hit_q;
    any_near_d = any_near_q;
    tally_d    = tally_q;
    big_acc_d  = big_acc_q;
    result_d   = result_q;
    wrong_d    = wrong_q;
    big_left_d = big_left_q;
    count_d    = count_q;
    biggest_d  = biggest_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (fire_edge_q && !game_over) begin
          if (illegal || !first_cell[4]) begin
            wrong_d = 1'b1;
          end else begin
            wrong_d    = 1'b0;
            cx_d       = x;
            cy_d       = y;
            big_sel_d  = big;
            cell_d     = first_cell[3:0];
            any_hit_d  = 1'b0;
            any_near_d = 1'b0;
            tally_d    = '0;
            big_acc_d  = '0;
            state_d    = ST_QUERY;
          end
        end
      end
      ST_QUERY: begin
        if (map_ack) begin
          any_hit_d  = hit_acc;
          any_near_d = near_acc;
          tally_d    = tally_acc;
          big_acc_d  = big_acc;
          if (later_cell[4]) begin
            cell_d = later_cell[3:0];
          end else begin
            // Results are committed on entry to DONE so they are already
            // visible while result_valid is high.
            state_d   = ST_DONE;
            result_d  = hit_acc ? RES_HIT : (near_acc ? RES_NEAR : RES_MISS);
            count_d   = count_sat;
            bcd_d     = bcd_add;
            ovf_d     = ovf_q | bcd_carry;
            biggest_d = big_acc;
            if (big_sel_q) big_left_d = big_left_q - BIG_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      fire_prev_q <= 1'b0;
      fire_edge_q <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      big_sel_q   <= 1'b0;
      cell_q      <= '0;
      any_hit_q   <= 1'b0;
      any_near_q  <= 1'b0;
      tally_q     <= '0;
      big_acc_q   <= '0;
      result_q    <= RES_NONE;
      wrong_q     <= 1'b0;
      big_left_q  <= BIG_W'(NUM_BIG);
      count_q     <= '0;
      biggest_q   <= '0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fire_prev_q <= fire;
      fire_edge_q <= fire & ~fire_prev_q;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      big_sel_q   <= big_sel_d;
      cell_q      <= cell_d;
      any_hit_q   <= any_hit_d;
      any_near_q  <= any_near_d;
      tally_q     <= tally_d;
      big_acc_q   <= big_acc_d;
      result_q    <= result_d;
      wrong_q     <= wrong_d;
      big_left_q  <= big_left_d;
      count_q     <= count_d;
      biggest_q   <= biggest_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
    end
  end

  assign map_req      = (state_q == ST_QUERY);
  assign map_x        = cx_q + COORD_W'(off_x(cell_q)) - ONE_C;
  assign map_y        = cy_q + COORD_W'(off_y(cell_q)) - ONE_C;
  assign result_valid = (state_q == ST_DONE);
  assign hit          = (result_q == RES_HIT);
  assign near_miss    = (result_q == RES_NEAR);
  assign miss         = (result_q == RES_MISS);
  assign wrong        = wrong_q;
  assign big_left     = big_left_q;
  assign hit_count    = count_q;
  assign biggest_hit  = biggest_q;
  assign game_over    = (count_q == TOTAL_C);
  assign state_dbg    = state_q;

  // Leading-zero blanking: a digit blanks when it and every higher digit
  // are zero; the units digit always shows.
  logic [NUM_DIGITS-1:0]      blank_v;
  logic                       lead_zero;
  logic [NUM_DIGITS-1:0][6:0] seg_raw;

  always_comb begin
    blank_v   = '0;
    lead_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero  = lead_zero && (bcd_q[i] == 4'd0);
      blank_v[i] = lead_zero && (i != 0);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_digit_blank u_digit (
      .bcd_i   (bcd_q[g]),
      .blank_i (blank_v[g]),
      .seg_o   (seg_raw[g])
    );
    assign hex[g] = ovf_q ? SEG_DASH : seg_raw[g];
  end

endmodule

// File: tb/tb_battleship_shot_engine.sv
module tb_battleship_shot_engine;

  localparam int GRID  = 10;
  localparam int TOTAL = 17;

  // ---------------- clock / reset / DUT ----------------
  logic            clock = 1'b0;
  logic            reset_L = 1'b0;
  logic            fire = 1'b0;
  logic [3:0]      x = '0, y = '0;
  logic            big = 1'b0;
  logic            map_req;
  logic [3:0]      map_x, map_y;
  logic            map_ack = 1'b0, map_hit = 1'b0, map_near = 1'b0;
  logic [2:0]      map_ship = '0;
  logic            result_valid, hit, near_miss, miss, wrong, game_over;
  logic [1:0]      big_left;
  logic [4:0]      hit_count;
  logic [2:0]      biggest_hit;
  logic [1:0][6:0] hex;
  logic [1:0]      state_dbg;

  always #5 clock = ~clock;

  battleship_shot_engine dut (
    .clock(clock), .reset_L(reset_L), .fire(fire), .x(x), .y(y), .big(big),
    .map_req(map_req), .map_x(map_x), .map_y(map_y), .map_ack(map_ack),
    .map_hit(map_hit), .map_near(map_near), .map_ship(map_ship),
    .result_valid(result_valid), .hit(hit), .near_miss(near_miss), .miss(miss),
    .wrong(wrong), .big_left(big_left), .hit_count(hit_count),
    .biggest_hit(biggest_hit), .game_over(game_over), .hex(hex),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];   // expected {map_x, map_y} in request order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ship map model + responder ----------------
  bit m_hit  [0:15][0:15];
  bit m_near [0:15][0:15];
  int m_ship [0:15][0:15];
  int ack_cnt = 0;
  bit stall = 1'b0;
  int wait_cnt = 0;

  always @(negedge clock) begin
    if (reset_L && map_req && !stall) begin
      if (wait_cnt == 0) begin
        map_ack  = 1'b1;
        map_hit  = m_hit[map_x][map_y];
        map_near = m_near[map_x][map_y];
        map_ship = m_hit[map_x][map_y] ? 3'(m_ship[map_x][map_y]) : 3'd0;
        ack_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got (%0d,%0d) expected no request", map_x, map_y);
        end else begin
          chk("req_cell", {24'd0, map_x, map_y}, {24'd0, exp_q.pop_front()});
        end
        wait_cnt = $urandom_range(0, 2);
      end else begin
        // Garbage on the data lines while not acking.
        map_ack  = 1'b0;
        map_hit  = 1'($urandom);
        map_near = 1'($urandom);
        map_ship = 3'($urandom);
        wait_cnt--;
      end
    end else begin
      map_ack  = 1'b0;
      map_hit  = 1'b0;
      map_near = 1'b0;
      map_ship = '0;
    end
  end

  // ---------------- reference model ----------------
  int m_count, m_bl, m_wrong, m_res, m_biggest;  // m_res: 0 none, 1 hit, 2 near, 3 miss

  task automatic model_reset();
    m_count = 0; m_bl = 3; m_wrong = 0; m_res = 0; m_biggest = 0;
  endtask

  task automatic model_shot(input int sx, input int sy, input int sb,
                            output int nreq, output int runs);
    int any_h, any_n, tally, bg, cx, cy;
    nreq = 0; runs = 0;
    if (m_count == TOTAL) return;
    if (sx < 1 || sx > GRID || sy < 1 || sy > GRID || (sb != 0 && m_bl == 0)) begin
      m_wrong = 1;
      return;
    end
    m_wrong = 0; runs = 1; any_h = 0; any_n = 0; tally = 0; bg = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (sb == 0 && (dx != 0 || dy != 0)) continue;
        cx = sx + dx; cy = sy + dy;
        if (cx < 1 || cx > GRID || cy < 1 || cy > GRID) continue;
        exp_q.push_back({4'(cx), 4'(cy)});
        nreq++;
        if (m_hit[cx][cy]) begin
          any_h = 1; tally++;
          if (m_ship[cx][cy] > bg) bg = m_ship[cx][cy];
        end
        if (m_near[cx][cy]) any_n = 1;
      end
    end
    m_res = any_h ? 1 : (any_n ? 2 : 3);
    m_count = (m_count + tally > TOTAL) ? TOTAL : m_count + tally;
    if (sb != 0) m_bl--;
    m_biggest = bg;
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] exp_hex(input int n);
    if (n >= 100) return {7'h3F, 7'h3F};
    return {(n / 10 == 0) ? 7'h7F : seg_of(n / 10), seg_of(n % 10)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_state(input string tag, input int e_wrong, input int e_res,
                             input int e_count, input int e_bl, input int e_big);
    chk({tag, ".wrong"},     32'(wrong),       32'(e_wrong));
    chk({tag, ".hit"},       32'(hit),         32'(e_res == 1));
    chk({tag, ".near"},      32'(near_miss),   32'(e_res == 2));
    chk({tag, ".miss"},      32'(miss),        32'(e_res == 3));
    chk({tag, ".hit_count"}, 32'(hit_count),   32'(e_count));
    chk({tag, ".big_left"},  32'(big_left),    32'(e_bl));
    chk({tag, ".biggest"},   32'(biggest_hit), 32'(e_big));
    chk({tag, ".game_over"}, 32'(game_over),   32'(e_count == TOTAL));
    chk({tag, ".hex"},       32'(hex),         32'(exp_hex(e_count)));
  endtask

  task automatic do_shot(input string tag, input int sx, input int sy, input int sb,
                         input int exp_run, input int e_wrong, input int e_res,
                         input int e_count, input int e_bl, input int e_big, input int e_reqs);
    int a0;
    int got;
    int saw_req;
    a0 = ack_cnt; got = 0; saw_req = 0;
    @(negedge clock);
    x = 4'(sx); y = 4'(sy); big = sb[0]; fire = 1'b1;
    if (exp_run != 0) begin
      for (int i = 0; i < 80; i++) begin
        @(negedge clock);
        if (result_valid) begin got = 1; break; end
      end
      chk({tag, ".result_valid"}, 32'(got), 32'd1);
      check_state(tag, e_wrong, e_res, e_count, e_bl, e_big);
      fire = 1'b0;
      @(negedge clock);
      chk({tag, ".rv_pulse"}, 32'(result_valid), 32'd0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clock);
        if (map_req) saw_req = 1;
        if (result_valid) got = 1;
      end
      chk({tag, ".no_req"},    32'(saw_req), 32'd0);
      chk({tag, ".no_result"}, 32'(got),     32'd0);
      check_state(tag, e_wrong, e_res, e_count, e_bl, e_big);
      fire = 1'b0;
      @(negedge clock);
    end
    chk({tag, ".req_count"}, 32'(ack_cnt - a0), 32'(e_reqs));
    chk({tag, ".exp_q_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_L = 1'b0; fire = 1'b0;
    repeat (2) @(negedge clock);
    exp_q.delete();
    wait_cnt = 0;
    reset_L = 1'b1;
    model_reset();
    @(negedge clock);
  endtask

  task automatic clear_map();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        m_hit[i][j] = 1'b0; m_near[i][j] = 1'b0; m_ship[i][j] = 0;
      end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int sx, sy, sb;
    int e_wrong, e_res, e_count, e_bl, e_big, e_reqs;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq, runs, sx, sy, sb;
    logic [13:0] h17;

    //            x   y  big  wrong res cnt bl big reqs
    vecs[0] = '{  3,  4, 0,   0,    1,  1,  3, 5,  1};
    vecs[1] = '{  1,  1, 1,   0,    2,  1,  2, 0,  4};
    vecs[2] = '{ 11,  5, 0,   1,    2,  1,  2, 0,  0};
    vecs[3] = '{  5,  5, 0,   0,    3,  1,  2, 0,  1};
    vecs[4] = '{  5,  5, 1,   0,    3,  1,  1, 0,  9};
    vecs[5] = '{ 10, 10, 1,   0,    3,  1,  0, 0,  4};
    vecs[6] = '{  4,  4, 1,   1,    3,  1,  0, 0,  0};
    vecs[7] = '{  0,  3, 0,   1,    3,  1,  0, 0,  0};
    vecs[8] = '{  3,  4, 0,   0,    1,  2,  0, 5,  1};

    clear_map();
    m_hit[3][4] = 1'b1; m_ship[3][4] = 5;
    m_near[2][2] = 1'b1;

    // Reset state
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset.map_req", 32'(map_req), 32'd0);
    chk("reset.result_valid", 32'(result_valid), 32'd0);
    chk("reset.state", 32'(state_dbg), 32'd0);
    chk("reset.hex_const", 32'(hex), 32'h3FC0);
    check_state("reset", 0, 0, 0, 3, 0);
    reset_L = 1'b1;
    @(negedge clock);
    check_state("released", 0, 0, 0, 3, 0);

    // Table-driven shots
    foreach (vecs[i]) begin
      model_shot(vecs[i].sx, vecs[i].sy, vecs[i].sb, nreq, runs);
      do_shot($sformatf("vec%0d", i), vecs[i].sx, vecs[i].sy, vecs[i].sb,
              (vecs[i].e_reqs > 0) ? 1 : 0, vecs[i].e_wrong, vecs[i].e_res,
              vecs[i].e_count, vecs[i].e_bl, vecs[i].e_big, vecs[i].e_reqs);
    end

    // Fill the counter to the end of the game
    for (int k = 3; k <= TOTAL; k++) begin
      model_shot(3, 4, 0, nreq, runs);
      do_shot($sformatf("fill%0d", k), 3, 4, 0, 1, 0, 1, k, 0, 5, 1);
    end
    h17 = {7'h79, 7'h78};
    chk("hex_17", 32'(hex), 32'(h17));
    chk("game_over_17", 32'(game_over), 32'd1);
    model_shot(3, 4, 0, nreq, runs);
    do_shot("after_over", 3, 4, 0, 0, 0, 1, TOTAL, 0, 5, 0);

    // Reset in the middle of a query
    do_reset();
    stall = 1'b1;
    @(negedge clock);
    x = 4'd5; y = 4'd5; big = 1'b0; fire = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (map_req) break;
    end
    chk("abort.req_up", 32'(map_req), 32'd1);
    #2 reset_L = 1'b0;
    #1;
    chk("abort.req_drop", 32'(map_req), 32'd0);
    chk("abort.state", 32'(state_dbg), 32'd0);
    chk("abort.result_valid", 32'(result_valid), 32'd0);
    fire = 1'b0;
    repeat (2) @(negedge clock);
    stall = 1'b0;
    exp_q.delete();
    wait_cnt = 0;
    reset_L = 1'b1;
    model_reset();
    @(negedge clock);
    check_state("abort.after", 0, 0, 0, 3, 0);

    // Randomised games against the model
    for (int g = 0; g < 4; g++) begin
      do_reset();
      clear_map();
      for (int i = 1; i <= GRID; i++)
        for (int j = 1; j <= GRID; j++) begin
          m_hit[i][j]  = ($urandom_range(0, 9) < 4);
          m_ship[i][j] = $urandom_range(1, 5);
          m_near[i][j] = ($urandom_range(0, 2) == 0);
        end
      for (int s = 0; s < 40; s++) begin
        if ($urandom_range(0, 9) == 0) begin
          sx = $urandom_range(0, 15); sy = $urandom_range(0, 15);
        end else begin
          sx = $urandom_range(1, GRID); sy = $urandom_range(1, GRID);
        end
        sb = ($urandom_range(0, 2) == 0) ? 1 : 0;
        model_shot(sx, sy, sb, nreq, runs);
        do_shot($sformatf("rnd%0d_%0d", g, s), sx, sy, sb, runs, m_wrong, m_res,
                m_count, m_bl, m_biggest, nreq);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
